stream_differencer: RTL and testbench

Streaming signed comb (differentiator) stage: for every accepted input sample x[n] it emits y[n] = x[n] − x[n−M], with M set by parameter. It is the inverse of the running-sum adder/integrator stages in the datapath. It sits on the decimation/interpolation side of the processing chain in the soc_system fabric, between valid/ready stream stages. Latency is one register stage, and full throughput is one sample per clock.

---
 rtl/stream_differencer.sv | 88 ++++++++
 tb/tb_stream_differencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/stream_differencer.sv
// Streaming signed comb stage: y[n] = x[n] - x[n-DELAY] behind a single-entry
// valid/ready output register, with optional saturation and a sticky overflow flag.
module stream_differencer #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DELAY    = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] D_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] Q_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             ovf_o
);

    logic [DELAY-1:0][WIDTH-1:0] hist_q, hist_d;
    logic [WIDTH-1:0]            q_q, q_d;
    logic                        valid_q, valid_d;
    logic                        ovf_q, ovf_d;

    logic                        accept;
    logic [WIDTH-1:0]            oldest;
    logic [WIDTH:0]              diff;
    logic                        overflow;
    logic [WIDTH-1:0]            result;

    // Readiness depends only on the output register, never on valid_i.
    assign ready_o  = ~rst_i & ~clr_i & (~valid_q | ready_i);
    assign accept   = valid_i & ready_o;

    assign oldest   = hist_q[DELAY-1];
    assign diff     = {D_i[WIDTH-1], D_i} - {oldest[WIDTH-1], oldest};
    assign overflow = diff[WIDTH] ^ diff[WIDTH-1];

    always_comb begin
        result = diff[WIDTH-1:0];
        if (SATURATE && overflow) begin
            // diff[WIDTH] is the true sign of the unbounded result.
            result = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        hist_d  = hist_q;
        q_d     = q_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            hist_d  = '0;
            q_d     = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            hist_d[0] = D_i;
            for (int i = 1; i < DELAY; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            q_d     = result;
            valid_d = 1'b1;
            ovf_d   = ovf_q | overflow;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q  <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Q_o     = q_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_stream_differencer.sv
// Directed bench for stream_differencer: several parameterisations share one
// stimulus stream; each scenario checks the instance it targets.
module tb_stream_differencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        vin;
    logic        rdy_in;
    logic [31:0] din;

    logic [31:0] q1, q3, q2;
    logic [7:0]  q8a, q8b;
    logic        v1, v3, v2, v8a, v8b;
    logic        r1, r3, r2, r8a, r8b;
    logic        o1, o3, o2, o8a, o8b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_differencer #(.WIDTH(32), .DELAY(1), .SATURATE(1'b0)) u_d1 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .D_i(din), .valid_i(vin), .ready_o(r1),
        .Q_o(q1), .valid_o(v1), .ready_i(rdy_in), .ovf_o(o1)
    );
    stream_differencer #(.WIDTH(32), .DELAY(3), .SATURATE(1'b0)) u_d3 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .D_i(din), .valid_i(vin), .ready_o(r3),
        .Q_o(q3), .valid_o(v3), .ready_i(rdy_in), .ovf_o(o3)
    );
    stream_differencer #(.WIDTH(32), .DELAY(2), .SATURATE(1'b0)) u_d2 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .D_i(din), .valid_i(vin), .ready_o(r2),
        .Q_o(q2), .valid_o(v2), .ready_i(rdy_in), .ovf_o(o2)
    );
    stream_differencer #(.WIDTH(8), .DELAY(1), .SATURATE(1'b0)) u_w8s0 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .D_i(din[7:0]), .valid_i(vin), .ready_o(r8a),
        .Q_o(q8a), .valid_o(v8a), .ready_i(rdy_in), .ovf_o(o8a)
    );
    stream_differencer #(.WIDTH(8), .DELAY(1), .SATURATE(1'b1)) u_w8s1 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .D_i(din[7:0]), .valid_i(vin), .ready_o(r8b),
        .Q_o(q8b), .valid_o(v8b), .ready_i(rdy_in), .ovf_o(o8b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic ri, input logic c);
        vin    = v;
        din    = d;
        rdy_in = ri;
        clr    = c;
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          ramp_exp [6] = '{1, 2, 3, 3, 3, 3};
    logic [31:0] ov_in    [6] = '{32'hFFFF_FF80, 32'h7F, 32'h0, 32'hFFFF_FF80, 32'h7F,
                                  32'hFFFF_FF80};
    logic [7:0]  ov_s0    [6] = '{8'h80, 8'hFF, 8'h81, 8'h80, 8'hFF, 8'h01};
    logic [7:0]  ov_s1    [6] = '{8'h80, 8'h7F, 8'h81, 8'h80, 8'h7F, 8'h80};
    logic        ov_flag  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        bp_ri    [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        bp_v     [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] bp_q     [7] = '{32'd10, 32'd10, 32'd10, 32'd20, 32'd20, 32'd20, 32'd0};
    logic [31:0] bp_src   [4] = '{32'd10, 32'd20, 32'd30, 32'd40};

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #3;
        check_eq("rst_ready", 64'(r1), 64'd0);
        check_eq("rst_valid", 64'(v1), 64'd0);
        check_eq("rst_q", 64'(q1), 64'd0);
        check_eq("rst_ovf", 64'(o1), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", 64'(r1), 64'd1);

        // Impulse on DELAY=1, full rate with no bubbles.
        drive(1'b1, 32'd5, 1'b1, 1'b0);
        tick();
        check_eq("imp0_q", 64'(q1), 64'd5);
        check_eq("imp0_v", 64'(v1), 64'd1);
        drive(1'b1, 32'd0, 1'b1, 1'b0);
        tick();
        check_eq("imp1_q", 64'(q1), 64'hFFFF_FFFB);
        check_eq("imp1_v", 64'(v1), 64'd1);
        tick();
        check_eq("imp2_q", 64'(q1), 64'd0);
        tick();
        check_eq("imp3_q", 64'(q1), 64'd0);
        check_eq("imp3_v", 64'(v1), 64'd1);
        check_eq("imp_ovf", 64'(o1), 64'd0);

        // Clear with valid input and stalled output: nothing accepted.
        drive(1'b1, 32'd99, 1'b0, 1'b1);
        #1;
        check_eq("clr_ready", 64'(r3), 64'd0);
        tick();
        check_eq("clr_v", 64'(v3), 64'd0);
        check_eq("clr_q", 64'(q3), 64'd0);

        // Ramp on DELAY=3.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(i + 1), 1'b1, 1'b0);
            tick();
            check_eq("ramp_q", 64'(q3), 64'(ramp_exp[i]));
            check_eq("ramp_v", 64'(v3), 64'd1);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        tick();
        check_eq("ramp_clr_v", 64'(v3), 64'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'd7, 1'b1, 1'b0);
            tick();
            check_eq("post_clr_q", 64'(q3), 64'd7);
        end

        // 8-bit overflow, wrap and saturate side by side.
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        tick();
        check_eq("ovf_clr", 64'(o8a), 64'd0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ov_in[i], 1'b1, 1'b0);
            tick();
            check_eq("wrap_q", 64'(q8a), 64'(ov_s0[i]));
            check_eq("sat_q", 64'(q8b), 64'(ov_s1[i]));
            check_eq("wrap_ovf", 64'(o8a), 64'(ov_flag[i]));
            check_eq("sat_ovf", 64'(o8b), 64'(ov_flag[i]));
        end

        // Asynchronous reset between edges while results are in flight.
        vin = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_v", 64'(v1), 64'd0);
        check_eq("arst_q", 64'(q1), 64'd0);
        check_eq("arst_q8", 64'(q8a), 64'd0);
        check_eq("arst_ovf_wrap", 64'(o8a), 64'd0);
        check_eq("arst_ovf_sat", 64'(o8b), 64'd0);
        check_eq("arst_ready", 64'(r1), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'd9, 1'b1, 1'b0);
        tick();
        check_eq("post_rst_q", 64'(q1), 64'd9);
        check_eq("post_rst_v", 64'(v1), 64'd1);

        // Backpressure on DELAY=2; source holds each sample until it is taken.
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        tick();
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 7; c++) begin
                drive(idx < 4, (idx < 4) ? bp_src[idx] : 32'd0, bp_ri[c], 1'b0);
                #1;
                check_eq("bp_ready", 64'(r2), 64'(bp_ri[c]));
                if (bp_ri[c] && idx < 4) idx++;
                tick();
                check_eq("bp_v", 64'(v2), 64'(bp_v[c]));
                if (bp_v[c]) check_eq("bp_q", 64'(q2), 64'(bp_q[c]));
            end
        end
        check_eq("bp_ovf", 64'(o2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
